nlp_btb: RTL

Parametrised next-line predictor for the IF0 stage: a small fully-associative branch target buffer with per-entry 2-bit bimodal counters. It serves `FETCH_WIDTH` consecutive instruction slots per cycle and accepts `NUM_UPD` independent training ports (IF3 pre-decode, backend resolution, …). Relative to the fixed 16-entry, 2-lane, 2-port predictor, it adds:
- parametrised depth, lanes and ports;
- counters trained from stored state;
- same-cycle duplicate merging;
- non-branch invalidation;
- a global flush;
- a hit counter.

---
 rtl/nlp_btb_if.sv | 29 ++
 rtl/nlp_btb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/nlp_btb_if.sv
// Lookup and training bus of the next-line BTB; the fetch/training side is master.
interface nlp_btb_if #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned NUM_UPD     = 2,
    parameter int unsigned PC_W        = 32
);
    logic                          flush;
    logic [PC_W-1:0]               lookup_pc;
    logic [FETCH_WIDTH-1:0]        lookup_valid;
    logic [FETCH_WIDTH-1:0]        lookup_taken;
    logic [FETCH_WIDTH*PC_W-1:0]   lookup_target;
    logic [FETCH_WIDTH*2-1:0]      lookup_bim;
    logic [NUM_UPD-1:0]            upd_valid;
    logic [NUM_UPD*PC_W-1:0]       upd_pc;
    logic [NUM_UPD*PC_W-1:0]       upd_target;
    logic [NUM_UPD-1:0]            upd_taken;
    logic [NUM_UPD-1:0]            upd_is_branch;
    logic [31:0]                   hit_count;

    modport master (
        output flush, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_branch,
        input  lookup_valid, lookup_taken, lookup_target, lookup_bim, hit_count
    );

    modport slave (
        input  flush, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_branch,
        output lookup_valid, lookup_taken, lookup_target, lookup_bim, hit_count
    );
endinterface

// File: rtl/nlp_btb.sv
// Fully-associative next-line BTB with 2-bit bimodal counters, multi-lane lookup,
// multi-port training, round-robin allocation, flush and a saturating hit counter.
module nlp_btb #(
    parameter int unsigned ENTRIES     = 16,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned NUM_UPD     = 2,
    parameter int unsigned PC_W        = 32
) (
    input logic       clk,
    input logic       rst,
    nlp_btb_if.slave  bus
);
    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = PC_W - 2;

    logic            valid_q [ENTRIES];
    logic            valid_d [ENTRIES];
    logic [TW-1:0]   tag_q   [ENTRIES];
    logic [TW-1:0]   tag_d   [ENTRIES];
    logic [PC_W-1:0] tgt_q   [ENTRIES];
    logic [PC_W-1:0] tgt_d   [ENTRIES];
    logic [1:0]      bim_q   [ENTRIES];
    logic [1:0]      bim_d   [ENTRIES];
    logic [IW-1:0]   head_q, head_d;
    logic [31:0]     hit_q, hit_d;

    logic [PC_W-1:0] lane_base;
    logic [TW-1:0]   lane_tag [FETCH_WIDTH];
    logic [TW-1:0]   upd_tag  [NUM_UPD];
    logic [NUM_UPD-1:0] act, hit;
    logic [IW-1:0]   hidx [NUM_UPD];
    logic [IW-1:0]   slot;
    int unsigned     nalloc;
    logic [7:0]      popcnt;
    logic [32:0]     hit_sum;
    logic            unused_upd_lsbs;

    always_comb begin
        lane_base = bus.lookup_pc & ~PC_W'(FETCH_WIDTH*4 - 1);
        for (int unsigned k = 0; k < FETCH_WIDTH; k++)
            lane_tag[k] = TW'((lane_base + PC_W'(4*k)) >> 2);
        unused_upd_lsbs = 1'b0;
        for (int unsigned p = 0; p < NUM_UPD; p++) begin
            upd_tag[p] = bus.upd_pc[p*PC_W+2 +: TW];
            unused_upd_lsbs = unused_upd_lsbs ^ (^bus.upd_pc[p*PC_W +: 2]);
        end
    end

    // Descending scan so the lowest matching index is the last (winning) write.
    always_comb begin
        bus.lookup_valid  = '0;
        bus.lookup_taken  = '0;
        bus.lookup_target = '0;
        bus.lookup_bim    = '0;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            for (int unsigned i = ENTRIES; i > 0; i--) begin
                if (valid_q[i-1] && tag_q[i-1] == lane_tag[k]) begin
                    bus.lookup_valid[k]              = 1'b1;
                    bus.lookup_taken[k]              = bim_q[i-1][1];
                    bus.lookup_target[k*PC_W +: PC_W] = tgt_q[i-1];
                    bus.lookup_bim[k*2 +: 2]         = bim_q[i-1];
                end
            end
        end
    end

    always_comb begin
        popcnt = '0;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++)
            popcnt = popcnt + 8'(bus.lookup_valid[k]);
        hit_sum = {1'b0, hit_q} + 33'(popcnt);
        hit_d   = hit_sum[32] ? '1 : hit_sum[31:0];
    end
    assign bus.hit_count = hit_q;

    // A port is dropped when a higher-index valid port carries the same PC.
    always_comb begin
        for (int unsigned p = 0; p < NUM_UPD; p++) begin
            act[p]  = bus.upd_valid[p];
            for (int unsigned q = p + 1; q < NUM_UPD; q++)
                if (bus.upd_valid[q] && upd_tag[q] == upd_tag[p])
                    act[p] = 1'b0;
            hit[p]  = 1'b0;
            hidx[p] = '0;
            for (int unsigned i = ENTRIES; i > 0; i--) begin
                if (valid_q[i-1] && tag_q[i-1] == upd_tag[p]) begin
                    hit[p]  = 1'b1;
                    hidx[p] = IW'(i-1);
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        bim_d   = bim_q;
        nalloc  = 0;
        slot    = '0;
        for (int unsigned p = 0; p < NUM_UPD; p++) begin
            if (act[p] && hit[p]) begin
                if (!bus.upd_is_branch[p]) begin
                    valid_d[hidx[p]] = 1'b0;
                end else if (bus.upd_taken[p]) begin
                    bim_d[hidx[p]] = (bim_q[hidx[p]] == 2'b11) ? 2'b11 : bim_q[hidx[p]] + 2'd1;
                    tgt_d[hidx[p]] = bus.upd_target[p*PC_W +: PC_W];
                end else begin
                    bim_d[hidx[p]] = (bim_q[hidx[p]] == 2'b00) ? 2'b00 : bim_q[hidx[p]] - 2'd1;
                end
            end
        end
        // Allocations after hit training so a reused victim takes the new contents.
        for (int unsigned p = 0; p < NUM_UPD; p++) begin
            if (act[p] && !hit[p] && bus.upd_is_branch[p]) begin
                if (nalloc < ENTRIES) begin
                    slot          = head_q + IW'(nalloc);
                    valid_d[slot] = 1'b1;
                    tag_d[slot]   = upd_tag[p];
                    tgt_d[slot]   = bus.upd_target[p*PC_W +: PC_W];
                    bim_d[slot]   = bus.upd_taken[p] ? 2'b10 : 2'b01;
                end
                nalloc = nalloc + 1;
            end
        end
        head_d = head_q + IW'(nalloc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                bim_q[i]   <= '0;
            end
            head_q <= '0;
            hit_q  <= '0;
        end else begin
            hit_q <= hit_d;
            if (bus.flush) begin
                for (int unsigned i = 0; i < ENTRIES; i++)
                    valid_q[i] <= 1'b0;
                head_q <= '0;
            end else begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= valid_d[i];
                    tag_q[i]   <= tag_d[i];
                    tgt_q[i]   <= tgt_d[i];
                    bim_q[i]   <= bim_d[i];
                end
                head_q <= head_d;
            end
        end
    end
endmodule
